// File: rtl/sync_multi_pkg.sv
// Shared primitives for the multi-channel synchroniser.
package sync_multi_pkg;

    // Number of bits needed to hold the values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        for (v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_multi_bit.sv
// One synchroniser channel: flop chain, stability filter and edge strobes.
module sync_multi_bit
    import sync_multi_pkg::*;
#(
    parameter int   STAGES = 2,
    parameter int   FILT   = 0,
    parameter logic INIT   = 1'b0
) (
    input  logic c,
    input  logic r,
    input  logic i,
    output logic o,
    output logic rise,
    output logic fall
);

    // FILT of 0 and 1 both mean "commit on the first differing cycle".
    localparam int FMAX = (FILT > 1) ? FILT : 1;
    localparam int CW   = (clog2(FMAX) > 0) ? clog2(FMAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FMAX - 1);

    // The chain is kept out of shift-register extraction and grouped so
    // all stages land in one slice with minimal routing between them.
    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO", RLOC = "X0Y0" *)
    logic [STAGES-1:0] sr;

    logic [CW-1:0] cnt;
    logic          s;
    logic          differ;
    logic          update;

    // NOTE: plain continuous assigns for combinational terms; nothing here
    // can hold state, so no latch can be inferred.
    assign s      = sr[STAGES-1];
    assign differ = s ^ o;
    assign update = differ && (cnt == CNT_LAST);

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge c or posedge r) begin
        // NOTE: the chain resets to INIT, the same value as o, so leaving
        // reset can never look like an edge.
        if (r) begin
            sr <= {STAGES{INIT}};
        end else begin
            // NOTE: non-blocking assignments so every stage samples the
            // previous stage's old value on the same edge.
            sr <= {sr[STAGES-2:0], i};
        end
    end

    // Stability filter: commit s to o once it has differed for FMAX cycles.
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            cnt <= '0;
            o   <= INIT;
        end else if (!differ) begin
            cnt <= '0;
        end else if (update) begin
            o   <= s;
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Edge strobes registered alongside o so they coincide with its change.
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= update & s;
            fall <= update & ~s;
        end
    end

endmodule

// File: rtl/sync_multi.sv
// W independent synchroniser channels with optional debounce and edge strobes.
module sync_multi
    import sync_multi_pkg::*;
#(
    parameter int           W      = 1,
    parameter int           STAGES = 2,
    parameter int           FILT   = 0,
    parameter logic [W-1:0] INIT   = {W{1'b0}}
) (
    input  logic         c,
    input  logic         r,
    input  logic [W-1:0] i,
    output logic [W-1:0] o,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    // Channels are deliberately uncoupled: a multi-bit value passed through
    // here may arrive with its bits on different cycles.
    for (genvar k = 0; k < W; k++) begin : g_ch
        sync_multi_bit #(
            .STAGES (STAGES),
            .FILT   (FILT),
            .INIT   (INIT[k])
        ) u_bit (
            .c    (c),
            .r    (r),
            .i    (i[k]),
            .o    (o[k]),
            .rise (rise[k]),
            .fall (fall[k])
        );
    end

endmodule

// File: tb/tb_sync_multi.sv
// Bench for sync_multi: three configurations checked against a windowed model.
module tb_sync_multi;

    // Instance a: defaults. Instance b: W=4, FILT=4, INIT=1010.
    // Instance c: W=8, STAGES=3, FILT=1.
    localparam int         ST     [3] = '{2, 2, 3};
    localparam int         FM     [3] = '{1, 4, 1};
    localparam logic [7:0] INIT_V [3] = '{8'h00, 8'h0A, 8'h00};

    logic       c;
    logic       r;
    logic [0:0] i_a, o_a, rise_a, fall_a;
    logic [3:0] i_b, o_b, rise_b, fall_b;
    logic [7:0] i_c, o_c, rise_c, fall_c;

    int n_checks = 0;
    int n_fails  = 0;
    int n_rise   = 0;
    int n_fall   = 0;
    logic cnt_en;

    sync_multi u_a (
        .c(c), .r(r), .i(i_a), .o(o_a), .rise(rise_a), .fall(fall_a)
    );

    sync_multi #(.W(4), .STAGES(2), .FILT(4), .INIT(4'b1010)) u_b (
        .c(c), .r(r), .i(i_b), .o(o_b), .rise(rise_b), .fall(fall_b)
    );

    sync_multi #(.W(8), .STAGES(3), .FILT(1)) u_c (
        .c(c), .r(r), .i(i_c), .o(o_c), .rise(rise_c), .fall(fall_c)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hist[k][n] is the input sampled n+1 edges ago. The value seen at the
    // chain output on an edge was sampled ST edges earlier. A bit flips on an
    // edge exactly when the last FM chain-output values all differ from it.
    logic [7:0]       in_v [3];
    logic [15:0][7:0] hist [3];
    logic [7:0]       eo [3];
    logic [7:0]       er [3];
    logic [7:0]       ef [3];

    assign in_v[0] = {7'b0, i_a};
    assign in_v[1] = {4'b0, i_b};
    assign in_v[2] = i_c;

    function automatic logic [7:0] flips(input logic [15:0][7:0] h, input int st,
                                         input int fm, input logic [7:0] cur);
        logic [7:0] m;
        m = 8'hFF;
        for (int j = 0; j < fm; j++) m = m & (h[st - 1 + j] ^ cur);
        return m;
    endfunction

    always @(posedge c or posedge r) begin
        logic [7:0] m;
        logic [7:0] nxt;
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                hist[k] <= {16{INIT_V[k]}};
                eo[k]   <= INIT_V[k];
                er[k]   <= 8'h00;
                ef[k]   <= 8'h00;
            end else begin
                m   = flips(hist[k], ST[k], FM[k], eo[k]);
                nxt = eo[k] ^ m;
                eo[k]   <= nxt;
                er[k]   <= m & nxt;
                ef[k]   <= m & ~nxt;
                hist[k] <= {hist[k][14:0], in_v[k]};
            end
        end
    end

    // Compare every cycle, half a period away from the active edge.
    always @(negedge c) begin
        check("a_o",    {7'b0, o_a},    eo[0]);
        check("a_rise", {7'b0, rise_a}, er[0]);
        check("a_fall", {7'b0, fall_a}, ef[0]);
        check("b_o",    {4'b0, o_b},    eo[1]);
        check("b_rise", {4'b0, rise_b}, er[1]);
        check("b_fall", {4'b0, fall_b}, ef[1]);
        check("c_o",    o_c,            eo[2]);
        check("c_rise", rise_c,         er[2]);
        check("c_fall", fall_c,         ef[2]);
    end

    // Strobe tally for the square-wave phase.
    always @(negedge c) begin
        if (cnt_en) begin
            n_rise <= n_rise + $countones(rise_c);
            n_fall <= n_fall + $countones(fall_c);
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [7:0] pat;
        pat    = 8'b1111_0111;   // s sequence 1,1,1,0,1,1,1,1 (bit 0 first)
        cnt_en = 1'b0;
        r      = 1'b0;
        i_a    = 1'b0;
        i_b    = 4'b1010;
        i_c    = 8'h00;

        // Asynchronous reset takes effect before any clock edge.
        #2 r = 1'b1;
        #1;
        check("rst_o_a", o_a, 0);
        check("rst_o_b", o_b, 4'b1010);
        check("rst_o_c", o_c, 8'h00);
        check("rst_strobes_b", {rise_b, fall_b}, 8'h00);

        @(negedge c);            // after edge 1
        @(negedge c);            // after edge 2
        r = 1'b0;

        // Defaults: i_a rises, sampled by edge 10, o_a shows it after edge 12.
        repeat (7) @(negedge c); // after edge 9
        i_a = 1'b1;
        repeat (2) @(negedge c); // after edge 11
        check("a_e11_o", o_a, 0);
        @(negedge c);            // after edge 12
        check("a_e12_o", o_a, 1);
        check("a_e12_rise", rise_a, 1);
        check("a_e12_fall", fall_a, 0);
        @(negedge c);            // after edge 13
        check("a_e13_rise", rise_a, 0);
        check("b_init_hold", o_b, 4'b1010);

        // FILT=4: a 2-cycle pulse on i_b[2] must never reach o.
        i_b[2] = 1'b1;
        repeat (2) @(negedge c);
        i_b[2] = 1'b0;
        repeat (10) begin
            @(negedge c);
            check("b_glitch_o", o_b, 4'b1010);
            check("b_glitch_strobes", {rise_b, fall_b}, 8'h00);
        end

        // 6-cycle hold on i_b[2]: set after edge k, o_b[2] rises after k+6.
        i_b[2] = 1'b1;
        repeat (5) @(negedge c); // k+5
        check("b_hold_k5_o", o_b, 4'b1010);
        @(negedge c);            // k+6
        check("b_hold_k6_o", o_b, 4'b1110);
        check("b_hold_k6_rise", rise_b, 4'b0100);
        check("b_hold_k6_fall", fall_b, 4'b0000);
        i_b[2] = 1'b0;
        @(negedge c);            // k+7
        check("b_hold_k7_rise", rise_b, 4'b0000);
        repeat (5) @(negedge c); // k+12: the release has gone the same path
        check("b_fall_k12_o", o_b, 4'b1010);
        check("b_fall_k12_fall", fall_b, 4'b0100);
        @(negedge c);

        // Restart: pattern set after edges k..k+7; the 0 discards progress.
        for (int p = 0; p < 8; p++) begin
            i_b[0] = pat[p];
            if (p < 7) @(negedge c);
        end
        repeat (2) @(negedge c); // k+9
        check("b_restart_k9_o", o_b, 4'b1010);
        @(negedge c);            // k+10
        check("b_restart_k10_o", o_b, 4'b1011);
        check("b_restart_k10_rise", rise_b, 4'b0001);

        // Reset with i_b[2] two counts into its filter.
        i_b[2] = 1'b1;
        repeat (4) @(negedge c);
        #2 r = 1'b1;
        #1;
        check("b_midrst_o", o_b, 4'b1010);
        check("b_midrst_strobes", {rise_b, fall_b}, 8'h00);
        check("a_midrst_o", o_a, 0);
        @(negedge c);            // m: reset held over one edge
        r = 1'b0;
        repeat (5) @(negedge c); // m+5
        check("b_postrst_m5_o", o_b, 4'b1010);
        @(negedge c);            // m+6
        check("b_postrst_m6_o", o_b, 4'b1111);
        check("b_postrst_m6_rise", rise_b, 4'b0101);

        // STAGES=3, FILT=1: square wave, half period 5 cycles, lag 4 edges.
        @(negedge c);            // k
        cnt_en = 1'b1;
        i_c    = 8'hA5;
        repeat (3) @(negedge c); // k+3
        check("c_lag_k3_o", o_c, 8'h00);
        @(negedge c);            // k+4
        check("c_lag_k4_o", o_c, 8'hA5);
        check("c_lag_k4_rise", rise_c, 8'hA5);
        @(negedge c);            // k+5
        i_c = 8'h5A;
        for (int t = 0; t < 4; t++) begin
            repeat (5) @(negedge c);
            i_c = i_c ^ 8'hFF;
        end
        repeat (6) @(negedge c);
        cnt_en = 1'b0;
        @(negedge c);
        // 00,A5,5A,A5,5A,A5,5A: A5 bits 3 rises/3 falls, 5A bits 3/2.
        check("c_rise_total", n_rise, 24);
        check("c_fall_total", n_fall, 20);
        check("c_final_o", o_c, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
